adc_cs5344: RTL and testbench

- Serial audio ADC receiver: master-mode deserializer for a CS5344-class ADC, 16-bit left-justified, 2 channels.
- Generates mclk, lrck and sclk from a clock-enable strobe.
- Shifts in sdout and presents parallel signed 16-bit left/right samples with a one-cycle valid strobe.
- Sits between the cartridge audio-in pins and the mixer; shares the same 512-phase frame timing as the DAC path, so one frame is one sample pair.

---
 rtl/adc_cs5344_pkg.sv | 22 ++
 rtl/adc_cs5344_ser_shift16.sv | 42 ++++
 rtl/adc_cs5344.sv | 148 ++++++++++++++
 tb/tb_adc_cs5344.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cs5344_pkg.sv
// rtl/adc_cs5344_pkg.sv - shared audio types and frame-timing constants
//
// Shared by the ADC receiver and, later, the mixer. The timing constants
// match the DAC path, so one 512-phase frame carries one sample pair.
package adc_cs5344_pkg;

    localparam int         PHASE_W     = 9;
    localparam int         SAMPLE_W    = 16;
    // Mid sclk-high point inside each 16-phase bit slot.
    localparam logic [3:0] BIT_CAPTURE = 4'hB;

    typedef logic signed [SAMPLE_W-1:0] snd_t;

    // Bundled receiver output for the mixer.
    typedef struct packed {
        snd_t l;
        snd_t r;
        logic valid;
        logic locked;
    } adc_out_t;

endpackage

// File: rtl/adc_cs5344_ser_shift16.sv
// rtl/adc_cs5344_ser_shift16.sv - 16-bit MSB-first serial-in shift register
//
// One bit enters at the LSB end on each clk with shift_en=1, so the first
// bit received ends up as the MSB after 16 shifts.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   shift_en  shift din in this clk
//   din       serial data bit
//   pdata     parallel word as it stands after this clk, including a bit
//             shifted in on this same clk; lets the owner latch a complete
//             word on the clk that delivers its last bit
module ser_shift16
    import adc_cs5344_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic                din,
    output logic [SAMPLE_W-1:0] pdata
);

    logic [SAMPLE_W-1:0] data_q;
    logic [SAMPLE_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            data_d = {data_q[SAMPLE_W-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign pdata = data_d;

endmodule

// File: rtl/adc_cs5344.sv
// rtl/adc_cs5344.sv - master-mode serial receiver for a CS5344-class audio ADC
//
// Generates mclk/sclk/lrck from a 512-phase frame counter that advances on
// ck_en, deserializes sdout into 16-bit left/right samples and presents them
// with a one-clk valid strobe once a warmup of WARMUP_FRAMES frames is over.
// Build option: ADC_I2S_FMT_EN selects Philips I2S (data one slot late);
// left-justified timing otherwise.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   ck_en         frame clock enable (44100*512 Hz strobe)
//   sdout         ADC serial data
//   mclk/sclk     ADC master and bit clocks
//   lrck          0 = left half-frame, 1 = right
//   snd_l/snd_r   held signed samples
//   sample_valid  one-clk pulse after snd_l/snd_r update
//   locked        warmup complete
module adc_cs5344
    import adc_cs5344_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int WARMUP_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ck_en,
    input  logic        sdout,
    output logic        mclk,
    output logic        lrck,
    output logic        sclk,
    output logic [15:0] snd_l,
    output logic [15:0] snd_r,
    output logic        sample_valid,
    output logic        locked
);

`ifdef ADC_I2S_FMT_EN
    localparam logic [PHASE_W-1:0] LEFT_LATCH  = 9'd267;
    localparam logic [PHASE_W-1:0] RIGHT_LATCH = 9'd11;
`else
    localparam logic [PHASE_W-1:0] LEFT_LATCH  = 9'd255;
    localparam logic [PHASE_W-1:0] RIGHT_LATCH = 9'd511;
`endif

    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    snd_t                   hold_l_q, hold_l_d;
    snd_t                   snd_l_q, snd_l_d;
    snd_t                   snd_r_q, snd_r_d;
    logic                   valid_q, valid_d;
    logic [3:0]             frame_ctr_q, frame_ctr_d;

    logic                   sdout_s;
    logic                   capture;
    logic                   right_sel;
    logic                   left_latch;
    logic                   right_latch;
    logic [SAMPLE_W-1:0]    l_pdata;
    logic [SAMPLE_W-1:0]    r_pdata;

    assign sdout_s     = sync_q[SYNC_STAGES-1];
    assign capture     = ck_en && (phase_q[3:0] == BIT_CAPTURE);
    assign left_latch  = ck_en && (phase_q == LEFT_LATCH);
    assign right_latch = ck_en && (phase_q == RIGHT_LATCH);
    assign locked      = (frame_ctr_q == 4'(WARMUP_FRAMES));

`ifdef ADC_I2S_FMT_EN
    // Slot 0 of each half-frame still carries the LSB of the other channel.
    assign right_sel = phase_q[8] ^ (phase_q[7:4] == 4'd0);
`else
    assign right_sel = phase_q[8];
`endif

    ser_shift16 u_shift_l (
        .clk      (clk),
        .rst      (rst),
        .shift_en (capture && !right_sel),
        .din      (sdout_s),
        .pdata    (l_pdata)
    );

    ser_shift16 u_shift_r (
        .clk      (clk),
        .rst      (rst),
        .shift_en (capture && right_sel),
        .din      (sdout_s),
        .pdata    (r_pdata)
    );

    always_comb begin
        sync_d[0] = sdout;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        phase_d     = phase_q;
        hold_l_d    = hold_l_q;
        snd_l_d     = snd_l_q;
        snd_r_d     = snd_r_q;
        frame_ctr_d = frame_ctr_q;
        // locked is the pre-update value: the frame that completes warmup
        // is itself discarded.
        valid_d     = right_latch && locked;

        if (ck_en) begin
            phase_d = phase_q + 1'b1;
        end
        if (left_latch) begin
            hold_l_d = l_pdata;
        end
        if (right_latch) begin
            snd_l_d = hold_l_q;
            snd_r_d = r_pdata;
            if (!locked) begin
                frame_ctr_d = frame_ctr_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            sync_q      <= '0;
            hold_l_q    <= '0;
            snd_l_q     <= '0;
            snd_r_q     <= '0;
            valid_q     <= 1'b0;
            frame_ctr_q <= '0;
        end else begin
            phase_q     <= phase_d;
            sync_q      <= sync_d;
            hold_l_q    <= hold_l_d;
            snd_l_q     <= snd_l_d;
            snd_r_q     <= snd_r_d;
            valid_q     <= valid_d;
            frame_ctr_q <= frame_ctr_d;
        end
    end

    assign mclk         = phase_q[0];
    assign sclk         = phase_q[3];
    assign lrck         = phase_q[8];
    assign snd_l        = snd_l_q;
    assign snd_r        = snd_r_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_adc_cs5344.sv
// tb/tb_adc_cs5344.sv - directed self-checking bench for adc_cs5344
module tb_adc_cs5344;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ck_en = 1'b0;
    logic        sdout = 1'b0;
    logic        mclk, lrck, sclk, sample_valid, locked;
    logic [15:0] snd_l, snd_r;

    int          checks = 0;
    int          errors = 0;

    // ADC model state: bench-side frame phase and words being transmitted.
    logic [8:0]  tb_phase = '0;
    logic [15:0] l_word = '0;
    logic [15:0] r_word = '0;
    logic [15:0] prev_r = '0;

    // Monitors updated every step.
    int          cyc = 0;
    int          pin_err = 0;
    int          vcount = 0;
    int          consec = 0;
    int          last_v = 0;
    int          last_v_prev = 0;
    logic        prev_valid = 1'b0;
    logic        mclk_prev = 1'b0, sclk_prev = 1'b0, lrck_prev = 1'b0;
    int          mclk_rise = 0, sclk_rise = 0, lrck_rise = 0;
    int          mclk_per = 0, sclk_per = 0, lrck_per = 0;
    int          v0;

    always #5 clk = ~clk;

    adc_cs5344 dut (
        .clk          (clk),
        .rst          (rst),
        .ck_en        (ck_en),
        .sdout        (sdout),
        .mclk         (mclk),
        .lrck         (lrck),
        .sclk         (sclk),
        .snd_l        (snd_l),
        .snd_r        (snd_r),
        .sample_valid (sample_valid),
        .locked       (locked)
    );

    function automatic logic model_bit();
        int slot;
        slot = int'(tb_phase[7:4]);
`ifdef ADC_I2S_FMT_EN
        if (slot == 0) return tb_phase[8] ? l_word[0] : prev_r[0];
        return tb_phase[8] ? r_word[16-slot] : l_word[16-slot];
`else
        return tb_phase[8] ? r_word[15-slot] : l_word[15-slot];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ce);
        ck_en = ce;
        sdout = model_bit();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            tb_phase = '0;
        end else if (ce) begin
            if (tb_phase == 9'd511) prev_r = r_word;
            tb_phase = tb_phase + 9'd1;
        end
        if ({mclk, sclk, lrck} !== {tb_phase[0], tb_phase[3], tb_phase[8]}) pin_err++;
        if (sample_valid === 1'b1) begin
            if (prev_valid) consec++;
            vcount++;
            last_v_prev = last_v;
            last_v = cyc;
        end
        prev_valid = (sample_valid === 1'b1);
        if (mclk === 1'b1 && mclk_prev === 1'b0) begin mclk_per = cyc - mclk_rise; mclk_rise = cyc; end
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin sclk_per = cyc - sclk_rise; sclk_rise = cyc; end
        if (lrck === 1'b1 && lrck_prev === 1'b0) begin lrck_per = cyc - lrck_rise; lrck_rise = cyc; end
        mclk_prev = mclk;
        sclk_prev = sclk;
        lrck_prev = lrck;
    endtask

    task automatic run(input int n, input logic ce);
        for (int i = 0; i < n; i++) step(ce);
    endtask

    task automatic run3(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_snd_l", snd_l, 16'h0000);
        check("rst_snd_r", snd_r, 16'h0000);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_pins", {mclk, sclk, lrck}, 3'b000);

`ifdef ADC_I2S_FMT_EN
        l_word = 16'h00FF;
        r_word = 16'hFF00;
        prev_r = 16'hFF00;
        run(2059, 1'b1);
        check("i2s_locked", locked, 1'b1);
        check("i2s_no_early_valid", vcount, 0);
        step(1'b1);
        check("i2s_valid", sample_valid, 1'b1);
        check("i2s_snd_l", snd_l, 16'h00FF);
        check("i2s_snd_r", snd_r, 16'hFF00);
        run(512, 1'b1);
        check("i2s_vcount", vcount, 2);
        check("i2s_interval", last_v - last_v_prev, 512);
        check("i2s_pins", pin_err, 0);
`else
        // Warmup and first valid sample
        l_word = 16'h8001;
        r_word = 16'h7FFE;
        run(2047, 1'b1);
        check("warm_locked_before", locked, 1'b0);
        step(1'b1);
        check("warm_locked_after", locked, 1'b1);
        check("warm_snd_l", snd_l, 16'h8001);
        check("warm_snd_r", snd_r, 16'h7FFE);
        check("warm_valid_low", sample_valid, 1'b0);
        run(512, 1'b1);
        check("first_valid", sample_valid, 1'b1);
        check("first_snd_l", snd_l, 16'h8001);
        check("first_snd_r", snd_r, 16'h7FFE);
        check("first_vcount", vcount, 1);
        run(1024, 1'b1);
        check("steady_vcount", vcount, 3);
        check("steady_interval", last_v - last_v_prev, 512);

        // Alternating frames: no channel swap, no bit slip
        for (int f = 0; f < 4; f++) begin
            l_word = f[0] ? 16'hFFFF : 16'h0000;
            r_word = f[0] ? 16'hAAAA : 16'h5555;
            run(512, 1'b1);
            check("alt_valid", sample_valid, 1'b1);
            check("alt_snd_l", snd_l, l_word);
            check("alt_snd_r", snd_r, r_word);
        end

        // Reset at phase 300
        l_word = 16'h1234;
        r_word = 16'h0F0F;
        run(300, 1'b1);
        check("pre_rst_locked", locked, 1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        check("mid_rst_snd_l", snd_l, 16'h0000);
        check("mid_rst_snd_r", snd_r, 16'h0000);
        check("mid_rst_valid", sample_valid, 1'b0);
        check("mid_rst_locked", locked, 1'b0);
        l_word = 16'hC3C3;
        r_word = 16'h3C3C;
        v0 = vcount;
        run(2048, 1'b1);
        check("recov_locked", locked, 1'b1);
        check("recov_no_valid", vcount, v0);
        run(512, 1'b1);
        check("recov_valid", sample_valid, 1'b1);
        check("recov_snd_l", snd_l, 16'hC3C3);
        check("recov_snd_r", snd_r, 16'h3C3C);

        // ck_en held low mid-frame
        l_word = 16'hABCD;
        r_word = 16'h1357;
        run(200, 1'b1);
        v0 = vcount;
        run(2000, 1'b0);
        check("freeze_no_valid", vcount, v0);
        check("freeze_pins", pin_err, 0);
        run(312, 1'b1);
        check("resume_valid", sample_valid, 1'b1);
        check("resume_snd_l", snd_l, 16'hABCD);
        check("resume_snd_r", snd_r, 16'h1357);

        // Pin waveforms with ck_en every third clk
        do_reset();
        l_word = 16'h8001;
        r_word = 16'h7FFE;
        run3(1024);
        check("mclk_period", mclk_per, 6);
        check("sclk_period", sclk_per, 48);
        check("lrck_period", lrck_per, 1536);
        check("pins_track_phase", pin_err, 0);
        check("slow_snd_l", snd_l, 16'h8001);
        check("total_vcount", vcount, 9);
`endif
        check("no_consecutive_valid", consec, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
